fetch_inst_queue: RTL
=====================

// Module: fetch_inst_queue
// PURPOSE
// - Instruction queue between the fetch stage and decode_top; decouples fetch stalls from decode stalls.
// - Fetch pushes {pc, inst, pred_taken} with a valid/ready handshake; decode pops from the head.
// - A pipeline flush (branch redirect / exception) empties the queue.
// - Entries are stored in registers; the head is presented first-word-fall-through from the storage array.
// PARAMETERS
// ADDR   `AddrWidth   PC width in bits
// INST   `InstWidth   instruction word width in bits
// DEPTH  4            number of entries; power of two, minimum 2
// PORTS
// clk            in   1               clock; all state updates on the rising edge
// reset_         in   1               asynchronous, active-low reset
// flush          in   1               discard every entry; no entry is accepted this cycle
// in_valid       in   1               fetch has an instruction to push
// in_ready       out  1               queue can accept; registered, equals (count != DEPTH)
// in_pc          in   ADDR            PC of the pushed instruction
// in_inst        in   INST            instruction word
// in_pred        in   1               branch-predicted-taken tag
// out_valid      out  1               head entry is valid; registered, equals (count != 0)
// out_ready      in   1               decode consumes the head this cycle
// out_pc         out  ADDR            head PC
// out_inst       out  INST            head instruction
// out_pred       out  1               head prediction tag
// count          out  $clog2(DEPTH)+1 current occupancy, 0..DEPTH
// BEHAVIOUR
// - Reset (reset_ == 0, asynchronous):
//   - rd_ptr, wr_ptr and count = 0; in_ready = 1; out_valid = 0.
//   - out_pc, out_inst and out_pred = 0; the storage array is not reset.
// - Handshakes:
//   - push = in_valid & in_ready & !flush.
//   - pop = out_valid & out_ready & !flush.
//   - A push writes entry[wr_ptr]; wr_ptr increments modulo DEPTH.
//   - A pop advances rd_ptr modulo DEPTH.
//   - Pointers are $clog2(DEPTH) bits wide and wrap naturally; full/empty are decoded from count only.
// - Latency:
//   - An entry pushed in cycle N is visible at the outputs (out_valid = 1) in cycle N+1 at the earliest.
//   - There is no same-cycle bypass from in_* to out_*.
// - Outputs:
//   - out_pc, out_inst and out_pred = entry[rd_ptr] when out_valid = 1.
//   - They are forced to 0 when out_valid = 0.
// - Count update:
//   - count_next = count + push - pop.
//   - Push and pop in the same cycle: count is unchanged and both pointers advance.
// - Full (count == DEPTH):
//   - in_ready = 0, so no push occurs even if a pop happens in the same cycle.
//   - in_ready returns to 1 in the cycle after the pop; this avoids a combinational ready path to fetch.
// - Empty (count == 0):
//   - out_valid = 0; out_ready is ignored.
//   - A push makes out_valid = 1 in the next cycle.
// - Flush:
//   - Highest priority: in the next cycle rd_ptr = wr_ptr = 0, count = 0, out_valid = 0 and in_ready = 1.
//   - Any push or pop offered in the flush cycle is discarded and is not counted.
// - Reset during operation: asynchronous clear as above; the queue behaves normally from the first edge after reset_ rises.
// - Inputs are sampled only at a rising edge; fetch must hold in_* stable while in_valid = 1 and in_ready = 0.
// TESTING
// 1. Reset -> in_ready = 1, out_valid = 0, count = 0, out_inst = 0.
// 2. Fill: push inst 0x00000013, 0x00100093, 0x00200113, 0x00300193 with out_ready = 0, DEPTH = 4
//    -> count = 4, in_ready = 0, out_inst = 0x00000013; a 5th push is not accepted.
// 3. Drain with out_ready = 1 -> out_inst sequence 0x13, 0x00100093, 0x00200113, 0x00300193
//    -> out_valid = 0 and count = 0 after the 4th pop.
// 4. Full plus pop with in_valid held: cycle N pops and count = 3; cycle N+1 in_ready = 1 and the push is accepted
//    -> count returns to 4.
// 5. Streaming with in_valid = out_ready = 1 continuously for 10 cycles at count = 2 -> count stays 2.
//    - PCs come out in push order 0x1000, 0x1004, ... with pointer wrap-around.
// 6. Flush at count = 3 with a concurrent push and pop -> next cycle count = 0, out_valid = 0, in_ready = 1.
//    - A following push of pc 0x2000 appears at out_pc one cycle later.

Source files
------------

// File: rtl/fetch_inst_queue.sv
// -----------------------------------------------------------------------------
// fetch_inst_queue
// Register-based instruction queue between the fetch stage and decode.
// Decouples fetch stalls from decode stalls. The head entry is presented
// first-word-fall-through from the storage array. A flush empties the queue.
//
// Ports
//   clk        in   clock, rising edge
//   reset_     in   asynchronous active-low reset
//   flush      in   discard all entries; nothing is accepted or popped this cycle
//   in_valid   in   fetch offers {in_pc, in_inst, in_pred}
//   in_ready   out  queue not full (decoded from the occupancy register)
//   in_pc      in   PC of the offered instruction
//   in_inst    in   instruction word
//   in_pred    in   predicted-taken tag
//   out_valid  out  queue not empty (decoded from the occupancy register)
//   out_ready  in   decode consumes the head
//   out_pc     out  head PC, zero when empty
//   out_inst   out  head instruction, zero when empty
//   out_pred   out  head prediction tag, zero when empty
//   count      out  occupancy, 0..Depth
// -----------------------------------------------------------------------------
module fetch_inst_queue #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned InstWidth = 32,
  parameter int unsigned Depth     = 4
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AddrWidth-1:0]       in_pc,
  input  logic [InstWidth-1:0]       in_inst,
  input  logic                       in_pred,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [AddrWidth-1:0]       out_pc,
  output logic [InstWidth-1:0]       out_inst,
  output logic                       out_pred,
  output logic [$clog2(Depth):0]     count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  // Storage array; intentionally not reset.
  logic [AddrWidth-1:0] r_pc_mem   [Depth];
  logic [InstWidth-1:0] r_inst_mem [Depth];
  logic                 r_pred_mem [Depth];

  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [CntW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Full/empty come only from the occupancy register, so in_ready has no
  // combinational path from out_ready.
  assign w_full  = (r_count == FullCnt);
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid & ~w_full & ~flush;
  assign w_pop   = ~w_empty & out_ready & ~flush;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= in_pc;
      r_inst_mem[r_wr_ptr] <= in_inst;
      r_pred_mem[r_wr_ptr] <= in_pred;
    end
  end

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign count     = r_count;

  // Head is forced to zero while empty so stale storage never leaks out.
  assign out_pc   = w_empty ? '0   : r_pc_mem[r_rd_ptr];
  assign out_inst = w_empty ? '0   : r_inst_mem[r_rd_ptr];
  assign out_pred = w_empty ? 1'b0 : r_pred_mem[r_rd_ptr];

endmodule
